// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b), LSB first, one bit per clock.
// A single full-subtractor cell and a borrow flop drive the datapath. Start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             ai, bi, d, bout, last;

  assign ai   = sa[0];
  assign bi   = sb[0];
  assign d    = ai ^ bi ^ borrow;
  assign bout = (~ai & bi) | (~(ai ^ bi) & borrow);
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result flags are only latched on the final bit, so they hold until the next run ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa         <= '0;
      sb         <= '0;
      borrow     <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa     <= a;
            sb     <= b;
            borrow <= 1'b0;
            cnt    <= '0;
          end
        end
        RUN: begin
          diff   <= {d, diff[WIDTH-1:1]};
          sa     <= {1'b0, sa[WIDTH-1:1]};
          sb     <= {1'b0, sb[WIDTH-1:1]};
          borrow <= bout;
          cnt    <= cnt + CW'(1);
          if (last) begin
            borrow_out <= bout;
            ovf        <= borrow ^ bout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
